// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: op encoding,
// sequencer states and the iteration count.
package muldiv_sequencer_pkg;

  localparam int MULDIV_ITER = 32;

  // Values match the RV32M funct3 field so the decoder can pass it through.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: radix-2 shift-add for multiply,
// restoring subtract for divide. Purely combinational.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div_i,
  input  logic [W-1:0]   opa_i,
  input  logic [2*W-1:0] prod_i,
  input  logic [W-1:0]   rem_i,
  input  logic [W-1:0]   quo_i,
  output logic [2*W-1:0] prod_o,
  output logic [W-1:0]   rem_o,
  output logic [W-1:0]   quo_o
);

  logic [W:0] mul_sum;
  logic [W:0] shifted;
  logic       ge;

  assign mul_sum = {1'b0, prod_i[2*W-1:W]} + (prod_i[0] ? {1'b0, opa_i} : '0);

  // The stored remainder is always below the divisor, so the W+1 bit working
  // value fits and the difference, when taken, fits back into W bits.
  assign shifted = {rem_i, quo_i[W-1]};
  assign ge      = shifted >= {1'b0, opa_i};

  assign prod_o = is_div_i ? prod_i : {mul_sum, prod_i[W-1:1]};
  assign rem_o  = !is_div_i ? rem_i
                : (ge ? (shifted[W-1:0] - opa_i) : shifted[W-1:0]);
  assign quo_o  = is_div_i ? {quo_i[W-2:0], ge} : quo_i;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU. One op at
// a time; stalls the pipe while iterating and returns a one-cycle result pulse.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_ITER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_src1,
  input  logic [DATA_WIDTH-1:0] req_src2,
  input  logic                  flush,
  output logic                  req_ready,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e  state_q;
  muldiv_op_e     op_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   opa_q, quo_q, rem_q;
  logic [2*W-1:0] prod_q;
  logic           neg_main_q, neg_rem_q;
  logic           resp_valid_q;
  logic [W-1:0]   resp_data_q;

  muldiv_op_e   in_op;
  logic         in_div, in_rem, s1_signed, s2_signed, s1_neg, s2_neg;
  logic         div_zero, div_ovf, accept;
  logic [W-1:0] a_mag, b_mag, fast_data;

  assign in_op = muldiv_op_e'(req_op);

  always_comb begin
    in_div    = op_is_div(in_op);
    in_rem    = in_op inside {OP_REM, OP_REMU};
    s1_signed = in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    s2_signed = in_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    s1_neg    = s1_signed && req_src1[W-1];
    s2_neg    = s2_signed && req_src2[W-1];
    a_mag     = s1_neg ? -req_src1 : req_src1;
    b_mag     = s2_neg ? -req_src2 : req_src2;
    div_zero  = in_div && (req_src2 == '0);
    div_ovf   = (in_op == OP_DIV || in_op == OP_REM) &&
                (req_src1 == MIN_NEG) && (req_src2 == '1);
    if (div_zero) fast_data = in_rem ? req_src1 : '1;
    else          fast_data = in_rem ? '0 : MIN_NEG;
  end

  assign accept    = (state_q == ST_IDLE) && req_valid && !flush;
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = accept || (state_q == ST_CALC) || (state_q == ST_FIX);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  logic [2*W-1:0] prod_nx;
  logic [W-1:0]   rem_nx, quo_nx;

  muldiv_step #(.W(W)) u_step (
    .is_div_i (op_is_div(op_q)),
    .opa_i    (opa_q),
    .prod_i   (prod_q),
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .prod_o   (prod_nx),
    .rem_o    (rem_nx),
    .quo_o    (quo_nx)
  );

  // Sign correction and result selection for the FIX cycle.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fix_data;

  always_comb begin
    prod_fix = neg_main_q ? -prod_q : prod_q;
    quo_fix  = neg_main_q ? -quo_q  : quo_q;
    rem_fix  = neg_rem_q  ? -rem_q  : rem_q;
    fix_data = rem_fix;
    case (op_q)
      OP_MUL:                      fix_data = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_data = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:             fix_data = quo_fix;
      default:                     fix_data = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_MUL;
      cnt_q        <= '0;
      opa_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      prod_q       <= '0;
      neg_main_q   <= 1'b0;
      neg_rem_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else if (flush) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp_valid_q <= 1'b0;
          if (req_valid) begin
            op_q       <= in_op;
            neg_main_q <= s1_neg ^ s2_neg;
            neg_rem_q  <= s1_neg;
            if (div_zero || div_ovf) begin
              resp_data_q  <= fast_data;
              resp_valid_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              opa_q   <= in_div ? b_mag : a_mag;
              prod_q  <= {{W{1'b0}}, b_mag};
              rem_q   <= '0;
              quo_q   <= a_mag;
              cnt_q   <= '0;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          prod_q <= prod_nx;
          rem_q  <= rem_nx;
          quo_q  <= quo_nx;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          resp_data_q  <= fix_data;
          resp_valid_q <= 1'b1;
          state_q      <= ST_DONE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus short random bench for muldiv_sequencer with an expected-value
// queue filled at issue time and drained when resp_valid pulses.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        req_ready, busy, resp_valid;
  logic [31:0] resp_data;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .flush      (flush),
    .req_ready  (req_ready),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the RV32M definition.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] pv;
    int ia, ib;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; pv = p; return pv[31:0]; end
      3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
      3'd2: begin p = sa * longint'({32'h0, b}); pv = p; return pv[63:32]; end
      3'd3: begin pv = {32'h0, a} * {32'h0, b}; return pv[63:32]; end
      3'd4: begin if (b == 0) return '1; if (ovf) return a; return ia / ib; end
      3'd5: begin if (b == 0) return '1; return a / b; end
      3'd6: begin if (b == 0) return a; if (ovf) return '0; return ia % ib; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  // Present one request for a single cycle; returns #1 into the cycle after.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_busy_acc"}, {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int lat, input string tag);
    int seen = 0;
    int at = 0;
    int busy_err = 0;
    logic [31:0] e;
    for (int i = 1; i <= 40 && seen == 0; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        seen = 1;
        at = i;
        if (busy !== 1'b0) busy_err++;
      end else if (i < lat && busy !== 1'b1) begin
        busy_err++;
      end
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_seen"}, seen, 32'd1);
    check({tag, "_lat"}, at, lat);
    check({tag, "_data"}, resp_data, e);
    check({tag, "_busy"}, busy_err, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    exp_q.push_back(exp);
    issue(op, a, b, tag);
    wait_resp(lat, tag);
  endtask

  task automatic no_resp(input int n, input string tag);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) pulses++;
    end
    check(tag, pulses, 32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rlat;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_data", resp_data, 32'd0);

    run_op(OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, "mulhsu");
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div");
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem");
    run_op(OP_DIVU,   32'd100,       32'd7,         32'd14,        34, "divu");
    run_op(OP_REMU,   32'd100,       32'd7,         32'd2,         34, "remu");

    run_op(OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_z");
    run_op(OP_REM,  32'd5,         32'd0,         32'd5,         1, "rem_z");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");

    // Abort in the 10th CALC cycle, then reissue.
    issue(OP_DIVU, 32'd100, 32'd7, "fl");
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("fl_busy_calc", {31'b0, busy}, 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("fl_idle", {31'b0, req_ready}, 32'd1);
    check("fl_busy", {31'b0, busy}, 32'd0);
    check("fl_valid", {31'b0, resp_valid}, 32'd0);
    no_resp(40, "fl_no_resp");
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "fl_redo");

    // Reset mid-CALC must clear resp_data as well.
    issue(OP_MUL, 32'd3, 32'd5, "rc");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rc_ready", {31'b0, req_ready}, 32'd1);
    check("rc_busy", {31'b0, busy}, 32'd0);
    check("rc_valid", {31'b0, resp_valid}, 32'd0);
    check("rc_data", resp_data, 32'd0);
    no_resp(40, "rc_no_resp");

    // Request coinciding with flush in IDLE is dropped.
    @(posedge clk); #1;
    req_valid = 1'b1; flush = 1'b1; req_op = OP_DIVU; req_src1 = 32'd9; req_src2 = 32'd3;
    @(negedge clk);
    check("fi_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("fi_ready", {31'b0, req_ready}, 32'd1);
    check("fi_busy2", {31'b0, busy}, 32'd0);
    no_resp(40, "fi_no_resp");

    for (int k = 0; k < 8; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom();
      rlat = (rop[2] && (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)))
             ? 1 : 34;
      run_op(rop, ra, rb, model(rop, ra, rb), rlat, $sformatf("rnd%0d_op%0d", k, rop));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide unit with its controlling state machine, attached to the execute stage beside the single-cycle ALU path. It accepts one M-extension operation at a time from the execute stage and stalls the pipeline while it iterates. It handles the divide-by-zero and signed-overflow fast paths, and returns a one-cycle result pulse that the execute stage forwards to writeback in place of the ALU result.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents an M-extension op.
- req_op  in  MulDivOp (3)  funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- req_src1  in  DATA_WIDTH  rs1 value (multiplicand / dividend).
- req_src2  in  DATA_WIDTH  rs2 value (multiplier / divisor).
- flush  in  1  pipeline flush; aborts any operation.
- req_ready  out  1  high iff state is IDLE.
- busy  out  1  stall request to the pipeline (combinational).
- resp_valid  out  1  one-cycle result pulse.
- resp_data  out  DATA_WIDTH  result; valid only while resp_valid is high.

## Operation
States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - Accept when req_valid && !flush.
  - Latch the op and the absolute values of the operands that are signed for this op. MULHSU: src1 signed, src2 unsigned.
  - Latch a negate flag. For multiply: sign(src1) XOR sign(src2) for the signed operands. For division: quotient flag = sign(src1) XOR sign(src2); remainder flag = sign(src1).
  - Divisor == 0: go to DONE. Result is all-ones for DIV/DIVU; src1 for REM/REMU.
  - DIV/REM with src1 = 0x80000000 and src2 = 0xFFFFFFFF: go to DONE. Result is 0x80000000 for DIV; 0 for REM.
  - Otherwise go to CALC with counter = 0.
- **CALC**
  - One iteration per cycle; counter increments.
  - When counter == DATA_WIDTH-1, go to FIX.
  - Multiply: radix-2 shift-add into a 2·DATA_WIDTH product register.
  - Divide: restoring division with a (DATA_WIDTH+1)-bit partial remainder; one quotient bit per cycle, MSB first.
- **FIX**
  - Apply the negate flag in two's complement at full width. The product negate is over 2·DATA_WIDTH bits.
  - Select the result: MUL gives the low half; MULH/MULHSU/MULHU give the high half; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register the result into resp_data and go to DONE.
- **DONE**
  - resp_valid = 1 for this cycle only; go to IDLE.
  - req_ready = 0, so a new request is never accepted in DONE.
- busy = (IDLE && req_valid && !flush) || CALC || FIX. busy is low in DONE, so the stage advances in the same cycle that it consumes resp_data.
- flush has priority over every other event:
  - In any state, the next state is IDLE.
  - No resp_valid is produced for the aborted op.
  - If flush coincides with req_valid in IDLE, the request is dropped.
- All arithmetic is unsigned on latched magnitudes. Results wrap at DATA_WIDTH with no exceptions.

## Timing
- Reset: state IDLE, counter 0, resp_valid 0, resp_data 0, internal registers 0. Consequently req_ready = 1 and busy = 0 from the first cycle after reset.
- While rst is high, requests are ignored.
- Normal op accepted at cycle T (IDLE): CALC runs T+1 … T+32, FIX at T+33, resp_valid at T+34. Latency is 34 cycles; busy is high from T through T+33.
- Fast path accepted at T: resp_valid at T+1; busy high only in T.
- Back-to-back ops: the next acceptance is possible at T+35 (normal) or T+2 (fast path).
- rst or flush mid-CALC or FIX: IDLE on the next edge; resp_valid stays 0.
- resp_data holds its last value after DONE. It is not cleared except by reset.

## Structure
- PipelineTypes gets:
  - the MulDivOp enum, matching the funct3 values above;
  - the MulDivState enum;
  - a MULDIV_ITER constant equal to DATA_WIDTH.
- One sub-module, muldiv_step: purely combinational, one shift-add or restore-subtract iteration. Inputs are the op class plus the current product/remainder/quotient registers; outputs are the next values.
- Sign handling, the fast paths and the FSM stay in the top module.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) accepted at T → resp_valid at T+34, resp_data 0xFFFFFFEB; busy high T…T+33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Fast paths, each with resp_valid at T+1:
  - DIVU 5 / 0 → 0xFFFFFFFF;
  - REM 5 / 0 → 5;
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000;
  - REM of the same operands → 0.
- flush asserted in the 10th CALC cycle → IDLE next cycle, resp_valid never asserted, busy low. A DIVU 100 / 7 issued immediately after returns 14 at acceptance+34.
- Two further cases:
  - rst asserted mid-CALC → all outputs at reset values next cycle;
  - req_valid with flush in IDLE → no acceptance, busy 0.
